// File: rtl/mario_plat_pkg.sv
// rtl/mario_plat_pkg.sv - shared types and constants for the Mario platform scanner
package mario_plat_pkg;

    localparam int DEF_CW    = 10;
    localparam int DEF_SPR_W = 23;
    localparam int DEF_SPR_H = 29;

    // Sliced down to the hit_idx width by the user; the floor marker is always all-ones.
    localparam logic [31:0] FLOOR_IDX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic              valid;
        logic [DEF_CW-1:0] left;
        logic [DEF_CW-1:0] right;
        logic [DEF_CW-1:0] top;
    } plat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mario_plat_table.sv
// rtl/mario_plat_table.sv - platform register file, one write port, combinational read
module mario_plat_table
    import mario_plat_pkg::*;
#(
    parameter int N_PLAT = 7,
    parameter int IW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] wr_idx,
    input  plat_t         wr_data,
    input  logic [IW-1:0] rd_idx,
    output plat_t         rd_data
);

    plat_t mem_q [N_PLAT];
    plat_t mem_d [N_PLAT];

    always_comb begin
        for (int i = 0; i < N_PLAT; i++) begin
            mem_d[i] = mem_q[i];
            if (we && (int'(wr_idx) == i)) begin
                mem_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PLAT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PLAT; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Out-of-range indices read as an invalid entry.
    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < N_PLAT) begin
            rd_data = mem_q[rd_idx];
        end
    end

endmodule

// File: rtl/mario_platform_scanner.sv
// rtl/mario_platform_scanner.sv - swept landing detector over a loadable platform table
// Optional ceiling bump detection is enabled with MARIO_PLAT_CEILING_EN.
module mario_platform_scanner
    import mario_plat_pkg::*;
#(
    parameter int N_PLAT  = 7,
    parameter int CW      = 10,
    parameter int SPR_W   = 23,
    parameter int SPR_H   = 29,
    parameter int FLOOR_Y = 440,
    parameter int BAR_H   = 8,
    localparam int IW     = (N_PLAT > 1) ? $clog2(N_PLAT) : 1,
    localparam int HW     = $clog2(N_PLAT) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          plat_we,
    input  logic [IW-1:0] plat_idx,
    input  logic [CW-1:0] plat_left,
    input  logic [CW-1:0] plat_right,
    input  logic [CW-1:0] plat_top,
    input  logic          plat_valid,
    input  logic          start,
    input  logic [CW-1:0] mario_x,
    input  logic [CW-1:0] mario_y,
    input  logic [CW-1:0] prev_y,
    output logic          busy,
    output logic          done,
    output logic          ground,
    output logic [CW-1:0] land_y,
    output logic [HW-1:0] hit_idx,
    output logic          bump,
    output logic [CW-1:0] bump_y
);

    localparam logic [CW:0]   SPR_W_E   = (CW+1)'(SPR_W);
    localparam logic [CW:0]   SPR_H_E   = (CW+1)'(SPR_H);
    localparam logic [CW:0]   FLOOR_Y_E = (CW+1)'(FLOOR_Y);
    localparam logic [CW:0]   FLOOR_LND = (FLOOR_Y_E >= SPR_H_E) ? (FLOOR_Y_E - SPR_H_E) : '0;
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_PLAT - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d, py_q, py_d;
    logic          best_hit_q, best_hit_d;
    logic [CW-1:0] best_top_q, best_top_d;
    logic [IW-1:0] best_idx_q, best_idx_d;
    logic          bmp_hit_q, bmp_hit_d;
    logic [CW:0]   bmp_und_q, bmp_und_d;
    logic          done_q, done_d, ground_q, ground_d, bump_q, bump_d;
    logic [CW-1:0] land_y_q, land_y_d, bump_y_q, bump_y_d;
    logic [HW-1:0] hit_idx_q, hit_idx_d;

    logic          tbl_we;
    plat_t         wr_ent, ent;
    logic [CW:0]   e_left, e_right, e_top, right_e, prev_bot, cur_bot;
    logic          x_ovl, ent_hit, nb_hit, nb_bmp;
    logic [CW-1:0] nb_top;
    logic [IW-1:0] nb_idx;
    logic [CW:0]   nb_und, und;

    assign wr_ent = '{valid: plat_valid, left: DEF_CW'(plat_left),
                      right: DEF_CW'(plat_right), top: DEF_CW'(plat_top)};

    mario_plat_table #(.N_PLAT(N_PLAT), .IW(IW)) u_table (
        .clk     (clk),
        .rst     (rst),
        .we      (tbl_we),
        .wr_idx  (plat_idx),
        .wr_data (wr_ent),
        .rd_idx  (idx_q),
        .rd_data (ent)
    );

    // Edges are widened by one bit so sprite offsets never wrap.
    always_comb begin
        e_left   = {1'b0, CW'(ent.left)};
        e_right  = {1'b0, CW'(ent.right)};
        e_top    = {1'b0, CW'(ent.top)};
        right_e  = {1'b0, x_q} + SPR_W_E;
        prev_bot = {1'b0, py_q} + SPR_H_E;
        cur_bot  = {1'b0, y_q} + SPR_H_E;
        und      = e_top + (CW+1)'(BAR_H);
        x_ovl    = (e_left <= right_e) && (e_right >= {1'b0, x_q});
        ent_hit  = ent.valid && x_ovl && (prev_bot <= e_top) && (e_top <= cur_bot);

        nb_hit = best_hit_q;
        nb_top = best_top_q;
        nb_idx = best_idx_q;
        if (ent_hit && (!best_hit_q || (CW'(ent.top) < best_top_q))) begin
            nb_hit = 1'b1;
            nb_top = CW'(ent.top);
            nb_idx = idx_q;
        end

        nb_bmp = bmp_hit_q;
        nb_und = bmp_und_q;
`ifdef MARIO_PLAT_CEILING_EN
        if (ent.valid && x_ovl && ({1'b0, py_q} >= und) && ({1'b0, y_q} < und) &&
            (!bmp_hit_q || (und > bmp_und_q))) begin
            nb_bmp = 1'b1;
            nb_und = und;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x_d        = x_q;
        y_d        = y_q;
        py_d       = py_q;
        best_hit_d = best_hit_q;
        best_top_d = best_top_q;
        best_idx_d = best_idx_q;
        bmp_hit_d  = bmp_hit_q;
        bmp_und_d  = bmp_und_q;
        ground_d   = ground_q;
        land_y_d   = land_y_q;
        hit_idx_d  = hit_idx_q;
        bump_d     = bump_q;
        bump_y_d   = bump_y_q;
        done_d     = 1'b0;
        tbl_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tbl_we = plat_we;
                if (start) begin
                    x_d        = mario_x;
                    y_d        = mario_y;
                    py_d       = prev_y;
                    best_hit_d = 1'b0;
                    best_top_d = '0;
                    best_idx_d = '0;
                    bmp_hit_d  = 1'b0;
                    bmp_und_d  = '0;
                    idx_d      = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                best_hit_d = nb_hit;
                best_top_d = nb_top;
                best_idx_d = nb_idx;
                bmp_hit_d  = nb_bmp;
                bmp_und_d  = nb_und;
                idx_d      = idx_q + IW'(1);
                // Results are registered on the last entry so they appear with done.
                if (idx_q == LAST_IDX) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    bump_d   = nb_bmp;
                    bump_y_d = nb_bmp ? nb_und[CW-1:0] : '0;
                    if (nb_hit) begin
                        ground_d  = 1'b1;
                        land_y_d  = (nb_top >= SPR_H_E[CW-1:0]) ? (nb_top - SPR_H_E[CW-1:0]) : '0;
                        hit_idx_d = HW'(nb_idx);
                    end else if (cur_bot >= FLOOR_Y_E) begin
                        ground_d  = 1'b1;
                        land_y_d  = FLOOR_LND[CW-1:0];
                        hit_idx_d = FLOOR_IDX[HW-1:0];
                    end else begin
                        ground_d  = 1'b0;
                        land_y_d  = y_q;
                        hit_idx_d = '0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            py_q       <= '0;
            best_hit_q <= 1'b0;
            best_top_q <= '0;
            best_idx_q <= '0;
            bmp_hit_q  <= 1'b0;
            bmp_und_q  <= '0;
            done_q     <= 1'b0;
            ground_q   <= 1'b0;
            land_y_q   <= '0;
            hit_idx_q  <= '0;
            bump_q     <= 1'b0;
            bump_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            y_q        <= y_d;
            py_q       <= py_d;
            best_hit_q <= best_hit_d;
            best_top_q <= best_top_d;
            best_idx_q <= best_idx_d;
            bmp_hit_q  <= bmp_hit_d;
            bmp_und_q  <= bmp_und_d;
            done_q     <= done_d;
            ground_q   <= ground_d;
            land_y_q   <= land_y_d;
            hit_idx_q  <= hit_idx_d;
            bump_q     <= bump_d;
            bump_y_q   <= bump_y_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign ground  = ground_q;
    assign land_y  = land_y_q;
    assign hit_idx = hit_idx_q;
    assign bump    = bump_q;
    assign bump_y  = bump_y_q;

endmodule
